// File: rtl/fetch_responder.sv
`default_nettype none
// ==== fetch_responder : in-order RV32 fetch responder, response FIFO, flush  ====
// ==== Optional macro FETCH_RSP_BYPASS_EN (return-cycle bypass)   Rev 1.0      ====
module fetch_responder #(
  parameter int MEM_LAT    = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_inst,
  output logic [31:0] rsp_pc,
  output logic        rsp_err,
  input  logic        flush
);

  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam logic [31:0] NOP     = 32'h00000013;
  localparam logic [1:0]  LAT_M1  = 2'(MEM_LAT - 1);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t        state_q;
  logic [1:0]    cnt_q;
  logic          drop_q;
  logic [31:0]   pend_pc_q;

  logic [31:0]           fifo_inst_q [FIFO_DEPTH];
  logic [31:0]           fifo_pc_q   [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_err_q;
  logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
  logic [PW:0]           count_q, count_d;

  logic        accept, aligned, ret_cycle, ret_live, fifo_empty, bypass, push, pop;
  logic [31:0] push_inst, push_pc;
  logic        push_err;

  assign req_ready  = rst & ~flush & (state_q == IDLE) & (count_q < DEPTH_C);
  assign accept     = req_valid & req_ready;
  assign aligned    = (req_addr[1:0] == 2'b00);
  assign mem_rd     = accept & aligned;
  assign mem_addr   = {req_addr[31:2], 2'b00};

  assign ret_cycle  = (state_q == WAIT) & (cnt_q == 2'd0);
  assign ret_live   = ret_cycle & ~drop_q & ~flush;
  assign fifo_empty = (count_q == '0);

`ifdef FETCH_RSP_BYPASS_EN
  assign bypass = ret_live & fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign rsp_valid = ~flush & (~fifo_empty | bypass);
  assign rsp_inst  = bypass ? mem_rdata : fifo_inst_q[rd_ptr_q];
  assign rsp_pc    = bypass ? pend_pc_q : fifo_pc_q[rd_ptr_q];
  assign rsp_err   = bypass ? 1'b0      : fifo_err_q[rd_ptr_q];

  // A bypassed response consumed in its return cycle never enters the FIFO.
  assign pop       = rsp_valid & rsp_ready & ~fifo_empty;
  assign push      = (ret_live & ~(bypass & rsp_ready)) | (accept & ~aligned);
  assign push_inst = ret_live ? mem_rdata : NOP;
  assign push_pc   = ret_live ? pend_pc_q : req_addr;
  assign push_err  = ~ret_live;

  assign count_d = flush ? '0 : (count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      drop_q    <= 1'b0;
      pend_pc_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_rd) begin
            state_q   <= WAIT;
            cnt_q     <= LAT_M1;
            pend_pc_q <= req_addr;
            drop_q    <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_q == 2'd0) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 2'd1;
            if (flush) drop_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fifo_err_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_inst_q[i] <= NOP;
        fifo_pc_q[i]   <= 32'd0;
      end
    end else begin
      count_q <= count_d;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          fifo_inst_q[wr_ptr_q] <= push_inst;
          fifo_pc_q[wr_ptr_q]   <= push_pc;
          fifo_err_q[wr_ptr_q]  <= push_err;
          wr_ptr_q              <= wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
